sample_iterator: RTL and testbench

//  Walks every sample position inside a triangle's bounding box in raster order, one per cycle.

---
 rtl/sample_iterator_if.sv | 40 ++++
 rtl/sample_iterator.sv | 146 ++++++++++++++
 tb/tb_sample_iterator.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_iterator_if.sv
`default_nettype none
// ============================================================================
//  Module   : sample_iterator_if
//  Purpose  : Bundles the bbox-stage inputs and sample-stage outputs of the
//             sample iterator into a single interface with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface sample_iterator_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    // Upstream (R13) side
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                   validTri_R13H;
    logic [3:0]                             subSample_RnnnnU;
    logic                                   halt_RnnnnL;

    // Downstream (R14) side
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                   validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_RnnnnL,
        input  tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_RnnnnL,
        output tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface
`default_nettype wire

// File: rtl/sample_iterator.sv
`default_nettype none
// ============================================================================
//  Module   : sample_iterator
//  Purpose  : Walks every sample position of a triangle's bounding box in
//             raster order, one sample per cycle, holding tri/color meanwhile.
//  Revision : 1.0 - initial release
// ============================================================================
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sample_iterator_if.slave  sif
);

    localparam logic [0:0] c_ST_WAIT = 1'b0;
    localparam logic [0:0] c_ST_TEST = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_next;

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
    logic [COLORS-1:0][SIGFIG-1:0]          r_color;
    logic signed [SIGFIG-1:0]               r_x;
    logic signed [SIGFIG-1:0]               r_y;
    logic signed [SIGFIG-1:0]               r_ll_x;
    logic signed [SIGFIG-1:0]               r_ur_x;
    logic signed [SIGFIG-1:0]               r_ur_y;
    logic [SIGFIG-1:0]                      r_step;

    logic [SIGFIG-1:0]       w_step_in;
    logic signed [SIGFIG:0]  w_x_adv;
    logic signed [SIGFIG:0]  w_y_adv;
    logic signed [SIGFIG:0]  w_ur_x_ext;
    logic signed [SIGFIG:0]  w_ur_y_ext;
    logic                    w_x_over;
    logic                    w_y_over;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_halt;
    logic                    w_valid;

    // One-hot MSAA mode placed so that 1x lands on 1.0 in fixed point.
    assign w_step_in = {{(SIGFIG-RADIX-1){1'b0}}, sif.subSample_RnnnnU, {(RADIX-3){1'b0}}};

    // One extra bit keeps x+step from wrapping before the signed compare.
    assign w_x_adv    = {r_x[SIGFIG-1], r_x} + {1'b0, r_step};
    assign w_y_adv    = {r_y[SIGFIG-1], r_y} + {1'b0, r_step};
    assign w_ur_x_ext = {r_ur_x[SIGFIG-1], r_ur_x};
    assign w_ur_y_ext = {r_ur_y[SIGFIG-1], r_ur_y};
    assign w_x_over   = (w_x_adv > w_ur_x_ext);
    assign w_y_over   = (w_y_adv > w_ur_y_ext);
    assign w_last     = w_x_over && w_y_over;

    assign w_accept   = sif.validTri_R13H && w_halt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_WAIT: begin
                if (w_accept) begin
                    w_state_next = c_ST_TEST;
                end
            end
            c_ST_TEST: begin
                if (w_last) begin
                    w_state_next = w_accept ? c_ST_TEST : c_ST_WAIT;
                end
            end
            default: w_state_next = c_ST_WAIT;
        endcase
    end

    // Output logic: ready for a new triangle when idle or on the final sample.
    always_comb begin
        w_halt  = 1'b1;
        w_valid = 1'b0;
        case (r_state)
            c_ST_WAIT: begin
                w_halt  = 1'b1;
                w_valid = 1'b0;
            end
            c_ST_TEST: begin
                w_halt  = w_last;
                w_valid = 1'b1;
            end
            default: begin
                w_halt  = 1'b1;
                w_valid = 1'b0;
            end
        endcase
    end

    // Triangle capture and raster stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tri   <= '0;
            r_color <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_ll_x  <= '0;
            r_ur_x  <= '0;
            r_ur_y  <= '0;
            r_step  <= '0;
        end else if (w_accept) begin
            r_tri   <= sif.tri_R13S;
            r_color <= sif.color_R13U;
            r_x     <= sif.box_R13S[0][0];
            r_y     <= sif.box_R13S[0][1];
            r_ll_x  <= sif.box_R13S[0][0];
            r_ur_x  <= sif.box_R13S[1][0];
            r_ur_y  <= sif.box_R13S[1][1];
            r_step  <= w_step_in;
        end else if ((r_state == c_ST_TEST) && !w_last) begin
            if (w_x_over) begin
                r_x <= r_ll_x;
                r_y <= w_y_adv[SIGFIG-1:0];
            end else begin
                r_x <= w_x_adv[SIGFIG-1:0];
            end
        end
    end

    assign sif.halt_RnnnnL    = w_halt;
    assign sif.validSamp_R14H = w_valid;
    assign sif.tri_R14S       = r_tri;
    assign sif.color_R14U     = r_color;
    assign sif.sample_R14S[0] = r_x;
    assign sif.sample_R14S[1] = r_y;

endmodule
`default_nettype wire

// File: tb/tb_sample_iterator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_iterator
//  Purpose  : Self-checking bench for sample_iterator against a sample-list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int ONE    = 1 << RADIX;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_iterator_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) sif ();

    sample_iterator #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sif(sif)
    );

    typedef struct {
        int                                 x;
        int                                 y;
        bit                                 last;
        logic [COLORS*SIGFIG-1:0]           color;
        logic [VERTS*AXIS*SIGFIG-1:0]       tri_v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   pending = 0;
    bit   exp_reset = 0;
    int   n_valid = 0;
    int   n_halt_low = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sample spacing implied by the MSAA mode: 1x=1.0, 4x=0.5, 16x=0.25, 64x=0.125
    function automatic int mode_step(input logic [3:0] mode);
        case (mode)
            4'b1000: return ONE;
            4'b0100: return ONE / 2;
            4'b0010: return ONE / 4;
            default: return ONE / 8;
        endcase
    endfunction

    // Expand the currently presented triangle into its full raster sample list.
    task automatic push_tri();
        int   llx, lly, urx, ury, st, nx, ny;
        exp_t e;
        llx = int'($signed(sif.box_R13S[0][0]));
        lly = int'($signed(sif.box_R13S[0][1]));
        urx = int'($signed(sif.box_R13S[1][0]));
        ury = int'($signed(sif.box_R13S[1][1]));
        st  = mode_step(sif.subSample_RnnnnU);
        nx  = (urx - llx) / st + 1;
        ny  = (ury - lly) / st + 1;
        for (int j = 0; j < ny; j++) begin
            for (int i = 0; i < nx; i++) begin
                e.x     = llx + i * st;
                e.y     = lly + j * st;
                e.last  = (i == nx - 1) && (j == ny - 1);
                e.color = sif.color_R13U;
                e.tri_v = sif.tri_R13S;
                q.push_back(e);
            end
        end
    endtask

    task automatic rand_payload();
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                sif.tri_R13S[v][a] = SIGFIG'($urandom());
        for (int c = 0; c < COLORS; c++)
            sif.color_R13U[c] = SIGFIG'($urandom());
    endtask

    task automatic load(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] mode);
        rand_payload();
        sif.box_R13S[0][0]   = llx[SIGFIG-1:0];
        sif.box_R13S[0][1]   = lly[SIGFIG-1:0];
        sif.box_R13S[1][0]   = urx[SIGFIG-1:0];
        sif.box_R13S[1][1]   = ury[SIGFIG-1:0];
        sif.subSample_RnnnnU = mode;
        sif.validTri_R13H    = 1'b1;
        pending              = 1'b1;
    endtask

    task automatic drive_random();
        logic [3:0] mode;
        int         st, llx, lly;
        if (pending) return;
        if ($urandom_range(0, 3) != 0) begin
            mode = 4'b0001 << $urandom_range(0, 3);
            st   = mode_step(mode);
            llx  = (int'($urandom_range(0, 40)) - 20) * st;
            lly  = (int'($urandom_range(0, 40)) - 20) * st;
            load(llx, lly, llx + int'($urandom_range(0, 3)) * st,
                 lly + int'($urandom_range(0, 3)) * st, mode);
        end else begin
            sif.validTri_R13H = 1'b0;
            // Mode may wander while idle or mid-walk; the DUT must use its latched copy.
            sif.subSample_RnnnnU = 4'b0001 << $urandom_range(0, 3);
        end
    endtask

    // One cycle: check outputs at the negedge, set inputs, advance the model.
    task automatic tick(input bit rnd);
        bit          eh, acc;
        logic [23:0] ex, ey;
        if (exp_reset) begin
            check("rst_sample", 256'(sif.sample_R14S), 256'(0));
            check("rst_color",  256'(sif.color_R14U),  256'(0));
            check("rst_tri",    256'(sif.tri_R14S),    256'(0));
            exp_reset = 1'b0;
        end
        if (q.size() > 0) begin
            ex = q[0].x[23:0];
            ey = q[0].y[23:0];
            check("valid", 256'(sif.validSamp_R14H), 256'(1));
            check("x",     256'(sif.sample_R14S[0]), 256'(ex));
            check("y",     256'(sif.sample_R14S[1]), 256'(ey));
            check("color", 256'(sif.color_R14U),     256'(q[0].color));
            check("tri",   256'(sif.tri_R14S),       256'(q[0].tri_v));
            check("halt",  256'(sif.halt_RnnnnL),    256'(q[0].last));
            eh = q[0].last;
            n_valid++;
            if (!eh) n_halt_low++;
        end else begin
            check("idle_valid", 256'(sif.validSamp_R14H), 256'(0));
            check("idle_halt",  256'(sif.halt_RnnnnL),    256'(1));
            eh = 1'b1;
        end
        if (rnd) drive_random();
        else if (!pending) sif.validTri_R13H = 1'b0;
        acc = sif.validTri_R13H && eh && !rst;
        if (q.size() > 0) void'(q.pop_front());
        if (rst) begin
            q.delete();
            pending   = 1'b0;
            exp_reset = 1'b1;
        end else if (acc) begin
            push_tri();
            pending = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && (q.size() > 0 || pending); i++) tick(1'b0);
        if (q.size() > 0 || pending) check("drain_timeout", 256'(1), 256'(0));
        tick(1'b0);
    endtask

    task automatic counts(input string tag, input int nv, input int nh);
        check({tag, "_count"},    256'(n_valid),    256'(nv));
        check({tag, "_haltlow"},  256'(n_halt_low), 256'(nh));
        n_valid    = 0;
        n_halt_low = 0;
    endtask

    initial begin
        rst                  = 1'b1;
        sif.validTri_R13H    = 1'b0;
        sif.subSample_RnnnnU = 4'b1000;
        sif.tri_R13S         = '0;
        sif.color_R13U       = '0;
        sif.box_R13S         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_reset = 1'b1;
        rst = 1'b0;
        tick(1'b0);
        n_valid = 0; n_halt_low = 0;

        // 1x, 3x2 box
        load(0, 0, 2 * ONE, ONE, 4'b1000);
        drain();
        counts("t1", 6, 5);

        // 4x, 3x3 at half-pixel spacing
        load(0, 0, ONE, ONE, 4'b0100);
        drain();
        counts("t2", 9, 8);

        // Degenerate box: single sample, halt never drops
        load(3 * ONE, 5 * ONE, 3 * ONE, 5 * ONE, 4'b1000);
        drain();
        counts("t3", 1, 0);

        // Back-to-back triangles with no bubble
        load(0, 0, ONE, 0, 4'b1000);
        tick(1'b0);
        load(4 * ONE, 4 * ONE, 5 * ONE, 5 * ONE, 4'b1000);
        drain();
        counts("t4", 6, 4);

        // Reset during the third sample of a nine-sample walk
        load(0, 0, ONE, ONE, 4'b0100);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);
        n_valid = 0; n_halt_low = 0;

        // Negative coordinates
        load(-2 * ONE, -ONE, -ONE, -ONE, 4'b1000);
        drain();
        counts("t6", 2, 1);

        // Randomized traffic including back-pressure and mode changes
        for (int k = 0; k < 600; k++) tick(1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
